// File: rtl/fault_pkg.sv
// fault_pkg: shared types and constants for the fault-injection checker.
//   result_e : per-run verdict encoding (3 reserved)
//   state_e  : checker control states
//   CYC_SAT  : all-ones saturation bound; consumers slice it to their counter width
package fault_pkg;
    typedef enum logic [1:0] {
        MASKED    = 2'd0,
        RECOVERED = 2'd1,
        FAILURE   = 2'd2
    } result_e;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;
    localparam int unsigned CNT_W_MAX = 64;
    localparam logic [CNT_W_MAX-1:0] CYC_SAT = '1;
endpackage

// File: rtl/fault_checker.sv
// fault_checker: replays a DUT against a golden state trace, flips one state bit at one cycle,
// and classifies the run as MASKED / RECOVERED / FAILURE.
//   clk, rst           : clock, async active-high reset
//   start              : pulse; latches cfg_cycle/cfg_bit and begins a run (ignored while running)
//   golden_valid/data  : golden state word for the current cycle; golden_ready acks it
//   dut_state_i        : live DUT state; dut_ce advances the DUT one cycle
//   inject_en/mask     : one-hot flip applied by the wrapper on the stepping edge
//   busy, done, result : run status and registered verdict
//   injected, first_mis_cycle, mis_count : run statistics
module fault_checker
    import fault_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int CNT_W      = 64,
    parameter int RUN_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [CNT_W-1:0]         cfg_cycle,
    input  logic [$clog2(WIDTH)-1:0] cfg_bit,
    input  logic                     golden_valid,
    input  logic [WIDTH-1:0]         golden_data,
    output logic                     golden_ready,
    input  logic [WIDTH-1:0]         dut_state_i,
    output logic                     dut_ce,
    output logic                     inject_en,
    output logic [WIDTH-1:0]         inject_mask,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               result,
    output logic                     injected,
    output logic [CNT_W-1:0]         first_mis_cycle,
    output logic [CNT_W-1:0]         mis_count
);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_SAT  = CYC_SAT[CNT_W-1:0];
    localparam logic [WIDTH-1:0] C_BIT0 = WIDTH'(1);

    state_e                   r_state, w_next;
    result_e                  r_result;
    logic [CNT_W-1:0]         r_cyc, r_cfg_cycle, r_mis_count, r_first_mis;
    logic [$clog2(WIDTH)-1:0] r_cfg_bit;
    logic                     r_injected, r_done, r_busy;
    logic                     w_step, w_mis, w_last, w_launch;

    assign w_step   = (r_state == RUN) && golden_valid;
    assign w_mis    = dut_state_i != golden_data;
    assign w_last   = r_cyc == C_LAST;
    assign w_launch = start && (r_state != RUN);

    always_comb begin
        w_next = r_state;
        if (w_launch)
            w_next = RUN;
        else if (w_step && w_last)
            w_next = DONE;
    end

    // Out-of-range cfg_bit shifts the bit out, giving an all-zero mask while still counting as injected.
    assign dut_ce          = w_step;
    assign golden_ready    = w_step;
    assign inject_en       = w_step && (r_cyc == r_cfg_cycle);
    assign inject_mask     = inject_en ? (C_BIT0 << r_cfg_bit) : '0;
    assign busy            = r_busy;
    assign done            = r_done;
    assign result          = r_result;
    assign injected        = r_injected;
    assign first_mis_cycle = r_first_mis;
    assign mis_count       = r_mis_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_result    <= MASKED;
            r_cyc       <= '0;
            r_cfg_cycle <= '0;
            r_cfg_bit   <= '0;
            r_mis_count <= '0;
            r_first_mis <= '0;
            r_injected  <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_launch) begin
                r_cfg_cycle <= cfg_cycle;
                r_cfg_bit   <= cfg_bit;
                r_cyc       <= '0;
                r_mis_count <= '0;
                r_first_mis <= '0;
                r_injected  <= 1'b0;
                r_done      <= 1'b0;
                r_busy      <= 1'b1;
            end else if (w_step) begin
                r_cyc <= r_cyc + C_ONE;
                if (w_mis && r_mis_count != C_SAT)
                    r_mis_count <= r_mis_count + C_ONE;
                if (w_mis && r_mis_count == '0)
                    r_first_mis <= r_cyc;
                if (inject_en)
                    r_injected <= 1'b1;
                // Verdict uses this step's compare: a mismatch on the final step is a failure.
                if (w_last) begin
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_result <= w_mis ? FAILURE : (r_mis_count == '0 && !w_mis) ? MASKED : RECOVERED;
                end
            end
        end
    end
endmodule

// File: tb/tb_fault_checker.sv
// tb_fault_checker: directed self-checking bench; models a counter DUT driven by dut_ce/inject_mask.
module tb_fault_checker;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] cfg_cycle = '0;
    logic [5:0]  cfg_bit = '0;
    logic        golden_valid = 1'b0;
    logic [63:0] golden_data;
    logic        golden_ready;
    logic [63:0] dut_state_i;
    logic        dut_ce, inject_en, busy, done, injected;
    logic [63:0] inject_mask, first_mis_cycle, mis_count;
    logic [1:0]  result;

    logic [63:0] q, k;
    logic        restore = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          lat, ce_low, inj_cnt;
    logic [63:0] inj_mask_seen;

    always #5 clk = ~clk;

    fault_checker dut (
        .clk(clk), .rst(rst), .start(start), .cfg_cycle(cfg_cycle), .cfg_bit(cfg_bit),
        .golden_valid(golden_valid), .golden_data(golden_data), .golden_ready(golden_ready),
        .dut_state_i(dut_state_i), .dut_ce(dut_ce), .inject_en(inject_en), .inject_mask(inject_mask),
        .busy(busy), .done(done), .result(result), .injected(injected),
        .first_mis_cycle(first_mis_cycle), .mis_count(mis_count)
    );

    // Counter DUT replica: golden trace is the cycle index, DUT state counts up with optional flip/restore.
    assign golden_data = k;
    assign dut_state_i = q;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
            k <= '0;
        end else if (start && !busy) begin
            q <= '0;
            k <= '0;
        end else if (dut_ce) begin
            k <= k + 64'd1;
            q <= (restore && k == 64'd20) ? k + 64'd1 : (q + 64'd1) ^ (inject_en ? inject_mask : 64'd0);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [63:0] c, input logic [5:0] b, input logic rest, input int stall);
        int left;
        left = stall;
        @(negedge clk);
        cfg_cycle = c;
        cfg_bit = b;
        restore = rest;
        start = 1'b1;
        golden_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("launch_done_low", {63'd0, done}, 64'd0);
        check("launch_busy_high", {63'd0, busy}, 64'd1);
        lat = 1;
        ce_low = 0;
        inj_cnt = 0;
        inj_mask_seen = '0;
        while (!done && lat < 200) begin
            golden_valid = !(left > 0 && k == 64'd30);
            if (!golden_valid) left--;
            #1;
            if (!golden_valid && !dut_ce) ce_low++;
            if (inject_en) begin
                inj_cnt++;
                inj_mask_seen = inject_mask;
            end
            @(negedge clk);
            lat++;
        end
        golden_valid = 1'b1;
    endtask

    initial begin
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_result", {62'd0, result}, 64'd0);
        check("rst_injected", {63'd0, injected}, 64'd0);
        check("rst_mis", mis_count, 64'd0);
        check("rst_first", first_mis_cycle, 64'd0);
        check("rst_ce", {63'd0, dut_ce}, 64'd0);
        check("rst_inj_en", {63'd0, inject_en}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run(64'd100, 6'd0, 1'b0, 0);
        check("clean_lat", 64'(lat), 64'd65);
        check("clean_result", {62'd0, result}, 64'd0);
        check("clean_injected", {63'd0, injected}, 64'd0);
        check("clean_mis", mis_count, 64'd0);
        check("clean_inj_cnt", 64'(inj_cnt), 64'd0);

        run(64'd10, 6'd3, 1'b0, 0);
        check("pers_result", {62'd0, result}, 64'd2);
        check("pers_first", first_mis_cycle, 64'd11);
        check("pers_mis", mis_count, 64'd53);
        check("pers_inj_cnt", 64'(inj_cnt), 64'd1);
        check("pers_mask", inj_mask_seen, 64'h8);
        check("pers_injected", {63'd0, injected}, 64'd1);
        repeat (3) @(negedge clk);
        check("done_hold", {63'd0, done}, 64'd1);
        check("done_hold_busy", {63'd0, busy}, 64'd0);

        run(64'd10, 6'd3, 1'b1, 0);
        check("trans_result", {62'd0, result}, 64'd1);
        check("trans_first", first_mis_cycle, 64'd11);
        check("trans_mis", mis_count, 64'd10);

        run(64'd10, 6'd3, 1'b0, 5);
        check("stall_lat", 64'(lat), 64'd70);
        check("stall_ce_low", 64'(ce_low), 64'd5);
        check("stall_result", {62'd0, result}, 64'd2);
        check("stall_mis", mis_count, 64'd53);
        check("stall_first", first_mis_cycle, 64'd11);

        @(negedge clk);
        restore = 1'b0;
        start = 1'b1;
        golden_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (k != 64'd30 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("midrst_reach", k, 64'd30);
        #2 rst = 1'b1;
        #1;
        check("midrst_ce", {63'd0, dut_ce}, 64'd0);
        check("midrst_inj_en", {63'd0, inject_en}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        check("midrst_result", {62'd0, result}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run(64'd100, 6'd0, 1'b0, 0);
        check("rerun_lat", 64'(lat), 64'd65);
        check("rerun_result", {62'd0, result}, 64'd0);
        check("rerun_mis", mis_count, 64'd0);

        run(64'd0, 6'd5, 1'b0, 0);
        check("c0_first", first_mis_cycle, 64'd1);
        check("c0_mis", mis_count, 64'd63);
        check("c0_result", {62'd0, result}, 64'd2);
        check("c0_mask", inj_mask_seen, 64'h20);

        run(64'd63, 6'd3, 1'b0, 0);
        check("c63_injected", {63'd0, injected}, 64'd1);
        check("c63_result", {62'd0, result}, 64'd0);
        check("c63_mis", mis_count, 64'd0);
        check("c63_inj_cnt", 64'(inj_cnt), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
